mem_responder: RTL and testbench

Memory-side responder for the `mem_ifa` test/memory protocol. It services `read`/`write`/`addr`/`data_in` from the test side, holds a 32 x 8 register-file store, and returns `data_out` with a fixed, parameterised read latency. It also flags illegal request combinations and keeps access counters for the bench's status report. It sits on the `mem_to_test` modport side of the interface.

---
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder: 2**ADDR_W x DATA_W store with a fixed RD_LAT-stage read
// pipeline, protocol-error flagging and saturating access counters.
module mem_responder #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              proto_err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Request protocol: read/write are sampled on every rising edge with no
  // handshake; 10 reads, 01 writes, 11 is an error that performs no access.
  logic rd_acc;
  logic wr_acc;
  logic err_req;

  assign rd_acc  = read & ~write;
  assign wr_acc  = write & ~read;
  assign err_req = read & write;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LAT-1:0] pipe_v;
  logic [DATA_W-1:0] pipe_d [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[addr] <= data_in;
    end
  end

  // Data stages load only alongside a valid bit, so the final stage keeps
  // the last returned read value while rd_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) begin
        pipe_d[0] <= mem[addr];
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

  assign data_out = pipe_d[RD_LAT-1];
  assign rd_valid = pipe_v[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
      err_count <= '0;
    end else begin
      proto_err <= err_req;
      if (wr_acc && (wr_count != '1)) begin
        wr_count <= wr_count + 1'b1;
      end
      if (rd_acc && (rd_count != '1)) begin
        rd_count <= rd_count + 1'b1;
      end
      if (err_req && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (RD_LAT 1/3/4, CNT_W 16/16/4) share
// one stimulus stream; a model store feeds per-instance expected read queues.
module tb_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;

  logic [7:0]  d1, d3, d4;
  logic        v1, v3, v4;
  logic        pe1, pe3, pe4;
  logic [15:0] wc1, rc1, ec1, wc3, rc3, ec3;
  logic [3:0]  wc4, rc4, ec4;

  int compared;
  int mismatched;

  logic [7:0] model_mem [32];
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  logic [7:0] q4[$];
  int wr_m, rd_m, err_m;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(d1), .rd_valid(v1), .proto_err(pe1),
    .wr_count(wc1), .rd_count(rc1), .err_count(ec1)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(d3), .rd_valid(v3), .proto_err(pe3),
    .wr_count(wc3), .rd_count(rc3), .err_count(ec3)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(d4), .rd_valid(v4), .proto_err(pe4),
    .wr_count(wc4), .rd_count(rc4), .err_count(ec4)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int x, input int maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  // Scoreboard: each instance pops its own queue whenever it returns data
  always @(negedge clk) begin
    if (v1) begin
      check("rd1_expected", q1.size() != 0, 1);
      if (q1.size() != 0) check("rd1_data", d1, q1.pop_front());
    end
    if (v3) begin
      check("rd3_expected", q3.size() != 0, 1);
      if (q3.size() != 0) check("rd3_data", d3, q3.pop_front());
    end
    if (v4) begin
      check("rd4_expected", q4.size() != 0, 1);
      if (q4.size() != 0) check("rd4_data", d4, q4.pop_front());
    end
  end

  // Driver: one request sampled at the next rising edge, then checks 1 ns later
  task automatic do_cycle(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
    read    = r;
    write   = w;
    addr    = a;
    data_in = d;
    if (r && !w) begin
      q1.push_back(model_mem[a]);
      q3.push_back(model_mem[a]);
      q4.push_back(model_mem[a]);
      rd_m++;
    end else if (w && !r) begin
      model_mem[a] = d;
      wr_m++;
    end else if (r && w) begin
      err_m++;
    end
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    check("perr1", pe1, r & w);
    check("perr3", pe3, r & w);
    check("perr4", pe4, r & w);
    check("wcnt1", wc1, sat(wr_m, 65535));
    check("rcnt1", rc1, sat(rd_m, 65535));
    check("ecnt1", ec1, sat(err_m, 65535));
    check("wcnt3", wc3, sat(wr_m, 65535));
    check("rcnt3", rc3, sat(rd_m, 65535));
    check("ecnt3", ec3, sat(err_m, 65535));
    check("wcnt4", wc4, sat(wr_m, 15));
    check("rcnt4", rc4, sat(rd_m, 15));
    check("ecnt4", ec4, sat(err_m, 15));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 5'h00, 8'h00);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_d1", d1, 0);
    check("rst_d3", d3, 0);
    check("rst_d4", d4, 0);
    check("rst_v", {v1, v3, v4}, 0);
    check("rst_perr", {pe1, pe3, pe4}, 0);
    check("rst_cnt1", {wc1, rc1, ec1}, 0);
    check("rst_cnt3", {wc3, rc3, ec3}, 0);
    check("rst_cnt4", {wc4, rc4, ec4}, 0);
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    q1.delete();
    q3.delete();
    q4.delete();
    wr_m  = 0;
    rd_m  = 0;
    err_m = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    read       = 1'b0;
    write      = 1'b0;
    addr       = '0;
    data_in    = '0;
    rst_n      = 1'b1;
    #2;
    apply_reset();

    // Single write then read-back
    do_cycle(1'b0, 1'b1, 5'h03, 8'hA5);
    do_cycle(1'b1, 1'b0, 5'h03, 8'h00);
    check("wr_rd_v1", v1, 1);
    check("wr_rd_d1", d1, 8'hA5);
    idle(5);
    check("d1_hold", d1, 8'hA5);
    check("v1_single", v1, 0);

    // Fill then 32 back-to-back reads; latency of first rd_valid per instance
    for (int i = 0; i < 32; i++) do_cycle(1'b0, 1'b1, 5'(i), 8'(8'h40 + i));
    for (int i = 0; i < 32; i++) begin
      do_cycle(1'b1, 1'b0, 5'(i), 8'h00);
      check("pipe_v1", v1, 1);
      check("pipe_v3", v3, i >= 2);
      check("pipe_v4", v4, i >= 3);
    end
    idle(6);

    // Protocol error must leave store and read pipeline untouched
    do_cycle(1'b0, 1'b1, 5'h07, 8'h11);
    do_cycle(1'b1, 1'b1, 5'h07, 8'hFF);
    check("err_no_v1", v1, 0);
    idle(5);
    check("err_no_v4", v4, 0);
    do_cycle(1'b1, 1'b0, 5'h07, 8'h00);
    check("err_rd_d1", d1, 8'h11);
    idle(5);

    // Random mix of idle/read/write/error
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 3);
      do_cycle(op >= 2, op[0], 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
    idle(6);

    // Reset two cycles after a read: in-flight data in RD_LAT 3/4 is discarded
    do_cycle(1'b1, 1'b0, 5'h03, 8'h00);
    do_cycle(1'b0, 1'b0, 5'h00, 8'h00);
    apply_reset();
    idle(8);
    check("rst_mid_d4", d4, 0);
    check("rst_mid_d3", d3, 0);
    for (int i = 0; i < 32; i++) do_cycle(1'b1, 1'b0, 5'(i), 8'h00);
    idle(6);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 20; i++) do_cycle(1'b0, 1'b1, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    check("wr_sat4", wc4, 15);
    check("wr_nosat1", wc1, 20);
    for (int i = 0; i < 32; i++) do_cycle(1'b1, 1'b0, 5'(i), 8'h00);
    idle(6);

    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    check("q4_drained", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
